// File: rtl/bcd_seq_conv_if.sv
// rtl/bcd_seq_conv_if.sv - start/busy/done handshake and result bundle for bcd_seq_conv
interface bcd_seq_conv_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    logic [DIGITS-1:0]     digit_en;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf, digit_en
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf, digit_en
    );
endinterface

// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Optional leading-zero blanking of digit_en under macro BCD_LEADING_ZERO_BLANK_EN.
module bcd_seq_conv #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_seq_conv_if.slave   cv
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   sreg, sreg_shift;
    logic [ACC_W-1:0]   acc, acc_adj, acc_shift;
    logic               ovf_flag, ovf_shift;
    logic [CNT_W-1:0]   cnt;
    logic               busy_r, done_r, ovf_r;
    logic [ACC_W-1:0]   bcd_r;
    logic               accept, last;

    assign accept = (state == IDLE) && cv.start;
    assign last   = (state == SHIFT) && (cnt == CNT_W'(1));

    // Add-3 per digit happens before the shift so the doubled digit carries correctly.
    always_comb begin
        acc_adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
        {acc_shift, sreg_shift} = {acc_adj[ACC_W-2:0], sreg, 1'b0};
        ovf_shift = ovf_flag | acc_adj[ACC_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cv.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= '0;
            acc      <= '0;
            ovf_flag <= 1'b0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            bcd_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                sreg     <= cv.bin;
                acc      <= '0;
                ovf_flag <= 1'b0;
                cnt      <= CNT_W'(BIN_W);
                busy_r   <= 1'b1;
            end else if (state == SHIFT) begin
                sreg     <= sreg_shift;
                acc      <= acc_shift;
                ovf_flag <= ovf_shift;
                cnt      <= cnt - CNT_W'(1);
                if (last) begin
                    bcd_r  <= acc_shift;
                    ovf_r  <= ovf_shift;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
            end
        end
    end

    assign cv.busy = busy_r;
    assign cv.done = done_r;
    assign cv.bcd  = bcd_r;
    assign cv.ovf  = ovf_r;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] en_nxt, en_r;
    logic              higher_nz;

    // A digit lights when it or any digit above it is nonzero; ovf lights everything.
    always_comb begin
        en_nxt    = '1;
        higher_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            higher_nz  = higher_nz | (acc_shift[4*k +: 4] != 4'd0);
            en_nxt[k]  = higher_nz | ovf_shift;
        end
        en_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            en_r <= '1;
        else if (last)
            en_r <= en_nxt;
    end

    assign cv.digit_en = en_r;
`else
    assign cv.digit_en = '1;
`endif
endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb/tb_bcd_seq_conv.sv - randomized and directed self-checking bench for bcd_seq_conv
module tb_bcd_seq_conv;
    localparam int BW = 8;
    localparam int DG = 3;
    localparam int BW2 = 16;
    localparam int DG2 = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    bcd_seq_conv_if #(.BIN_W(BW),  .DIGITS(DG))  a ();
    bcd_seq_conv_if #(.BIN_W(BW2), .DIGITS(DG2)) b ();

    bcd_seq_conv #(.BIN_W(BW),  .DIGITS(DG))  u8  (.clk(clk), .rst_n(rst_n), .cv(a));
    bcd_seq_conv #(.BIN_W(BW2), .DIGITS(DG2)) u16 (.clk(clk), .rst_n(rst_n), .cv(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pow10(input int k);
        logic [63:0] p = 64'd1;
        for (int i = 0; i < k; i++) p = p * 64'd10;
        return p;
    endfunction

    // Decimal digits of v modulo 10**dg, packed 4 bits per digit.
    function automatic logic [63:0] to_bcd(input logic [63:0] v, input int dg);
        logic [63:0] r = '0;
        logic [63:0] m = v % pow10(dg);
        for (int k = 0; k < dg; k++) r[4*k +: 4] = 4'((m / pow10(k)) % 64'd10);
        return r;
    endfunction

    function automatic logic [15:0] en_model(input logic [63:0] v, input int dg);
        logic [15:0] e = '0;
        for (int k = 0; k < dg; k++) begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            e[k] = (k == 0) || (v >= pow10(k)) || (v >= pow10(dg));
`else
            e[k] = 1'b1;
`endif
        end
        return e;
    endfunction

    // Transaction-level model of the 8-bit instance: accept, wait BIN_W edges, publish.
    logic        m_busy, m_done, m_ovf;
    logic [63:0] m_bcd, m_cap;
    logic [15:0] m_en;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0;
            m_bcd  <= '0;   m_cap  <= '0;   m_en  <= 16'hffff; m_left <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (a.start) begin
                m_busy <= 1'b1;
                m_left <= BW;
                m_cap  <= 64'(a.bin);
            end
        end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_bcd  <= to_bcd(m_cap, DG);
            m_ovf  <= (m_cap >= pow10(DG));
            m_en   <= en_model(m_cap, DG);
        end else begin
            m_left <= m_left - 1;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(a.busy), 64'(m_busy));
        check("done", 64'(a.done), 64'(m_done));
        check("bcd", 64'(a.bcd), m_bcd[4*DG-1:0]);
        check("ovf", 64'(a.ovf), 64'(m_ovf));
        check("digit_en", 64'(a.digit_en), 64'(m_en[DG-1:0]));
    end

    task automatic wait_done8(output int n);
        n = 1;
        while (!a.done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic convert8(input logic [BW-1:0] v, input logic [11:0] exp_bcd, input string name);
        int n;
        @(negedge clk);
        a.start = 1'b1;
        a.bin   = v;
        @(negedge clk);
        a.start = 1'b0;
        a.bin   = BW'($urandom);
        wait_done8(n);
        check({name, "_latency"}, 64'(n), 64'(BW + 1));
        check({name, "_bcd"}, 64'(a.bcd), 64'(exp_bcd));
    endtask

    task automatic convert16(input logic [BW2-1:0] v, input logic [15:0] exp_bcd,
                             input logic exp_ovf, input string name);
        int n;
        @(negedge clk);
        b.start = 1'b1;
        b.bin   = v;
        @(negedge clk);
        b.start = 1'b0;
        n = 1;
        while (!b.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(BW2 + 1));
        check({name, "_bcd"}, 64'(b.bcd), 64'(exp_bcd));
        check({name, "_ovf"}, 64'(b.ovf), 64'(exp_ovf));
        check({name, "_en"}, 64'(b.digit_en), 64'(en_model(64'(v), DG2)));
    endtask

    initial begin
        int n, t1;
        logic [BW2-1:0] r16;
        rst_n   = 1'b0;
        a.start = 1'b0; a.bin = '0;
        b.start = 1'b0; b.bin = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(a.busy), 64'd0);
        check("rst_bcd", 64'(a.bcd), 64'd0);
        check("rst_en", 64'(a.digit_en), 64'h7);
        check("rst_bcd16", 64'(b.bcd), 64'd0);
        rst_n = 1'b1;

        convert8(8'd255, 12'h255, "t1_255");
        check("t1_ovf", 64'(a.ovf), 64'd0);
        convert8(8'd0,   12'h000, "t2_0");
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check("t6_en_0", 64'(a.digit_en), 64'b001);
`else
        check("t6_en_0", 64'(a.digit_en), 64'b111);
`endif
        convert8(8'd9,   12'h009, "t2_9");
        convert8(8'd100, 12'h100, "t2_100");
        convert8(8'd59,  12'h059, "t2_59");
        convert8(8'd7,   12'h007, "t6_7");
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check("t6_en_7", 64'(a.digit_en), 64'b001);
`else
        check("t6_en_7", 64'(a.digit_en), 64'b111);
`endif
        convert8(8'd105, 12'h105, "t6_105");
        check("t6_en_105", 64'(a.digit_en), 64'b111);

        // Back-to-back with start held; bin changes right after the first accept.
        @(negedge clk);
        a.start = 1'b1;
        a.bin   = 8'd37;
        @(negedge clk);
        a.bin   = 8'd200;
        wait_done8(n);
        t1 = cyc;
        check("t3_first", 64'(a.bcd), 64'h037);
        @(negedge clk);
        n = 1;
        while (!a.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        a.start = 1'b0;
        check("t3_spacing", 64'(cyc - t1), 64'(BW + 1));
        check("t3_second", 64'(a.bcd), 64'h200);
        repeat (BW + 3) @(negedge clk);

        // Reset mid-conversion abandons it.
        @(negedge clk);
        a.start = 1'b1;
        a.bin   = 8'd99;
        @(negedge clk);
        a.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy", 64'(a.busy), 64'd0);
        check("t5_done", 64'(a.done), 64'd0);
        check("t5_bcd", 64'(a.bcd), 64'd0);
        rst_n = 1'b1;
        convert8(8'd42, 12'h042, "t5_42");

        // Random start/bin traffic against the model, including starts while busy.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            a.start = ($urandom_range(0, 2) == 0);
            a.bin   = BW'($urandom);
        end
        a.start = 1'b0;
        repeat (BW + 3) @(negedge clk);

        convert16(16'd65535, 16'h5535, 1'b1, "t4_65535");
        convert16(16'd9999,  16'h9999, 1'b0, "t4_9999");
        for (int i = 0; i < 6; i++) begin
            r16 = BW2'($urandom);
            convert16(r16, to_bcd(64'(r16), DG2)[15:0], r16 >= 16'd10000, "t4_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
